mult_div_ctrl: RTL and testbench
================================

MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 40, meaning the number of RUN cycles without UnitDone before a timeout exception (used only with MDC_TIMEOUT_EN).
REQ-002 SHALL have port Clock  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port Start  input  1  request from the main control unit, sampled only in IDLE.
REQ-005 SHALL have port Op  input  1  operation select: 0 = mult, 1 = div; latched on an accepted Start.
REQ-006 SHALL have port DivZero  input  1  divisor-is-zero flag from the datapath, sampled with Start.
REQ-007 SHALL have port UnitDone  input  1  completion flag from the mult/div unit.
REQ-008 SHALL have port MultStart  output  1  one-cycle start pulse to the multiplier.
REQ-009 SHALL have port DivStart  output  1  one-cycle start pulse to the divider.
REQ-010 SHALL have port DivMult  output  1  HI/LO source mux select: 0 = multiplier, 1 = divider.
REQ-011 SHALL have port RegHighW  output  1  HI register write enable.
REQ-012 SHALL have port RegLowW  output  1  LO register write enable.
REQ-013 SHALL have port Busy  output  1  operation in progress; the main control stalls while it is high.
REQ-014 SHALL have port Done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port ExcpOut  output  1  one-cycle exception pulse.
REQ-016 SHALL have port ExcpCode  output  2  exception cause: 00 none, 01 divide by zero, 10 timeout; valid while ExcpOut=1, 00 otherwise.

Function
REQ-017 SHALL implement the states IDLE, START, RUN, WRITE, DONE and EXCP, with all outputs decoded from the state register and the latched Op.
REQ-018 In IDLE with Start=1, SHALL latch Op and go to EXCP with cause 01 if Op=1 and DivZero=1; otherwise it SHALL go to START.
REQ-019 In IDLE with Start=0, SHALL remain in IDLE with all outputs 0.
REQ-020 In START, SHALL assert MultStart (latched Op=0) or DivStart (latched Op=1) for exactly one cycle, assert Busy, clear the RUN cycle counter, then go to RUN.
REQ-021 In RUN, SHALL assert Busy and go to WRITE when UnitDone=1; otherwise it SHALL increment the counter and stay in RUN.
REQ-022 UnitDone SHALL be ignored in every state except RUN.
REQ-023 In WRITE, SHALL assert RegHighW=1, RegLowW=1 and Busy=1 for one cycle, then go to DONE.
REQ-024 DivMult SHALL equal the latched Op in START, RUN and WRITE, and SHALL be 0 otherwise.
REQ-025 In DONE, SHALL assert Done=1 with Busy=0 for one cycle, then go to IDLE.
REQ-026 In EXCP, SHALL assert ExcpOut=1, drive ExcpCode and hold Busy=0 for one cycle, then go to IDLE; HI/LO SHALL never be written on an exception path.
REQ-027 Start SHALL be ignored in all states other than IDLE, including DONE and EXCP; a new request is accepted no earlier than the cycle after return to IDLE.
REQ-028 Minimum latency SHALL be: Start accepted in cycle 0, START in cycle 1, RUN in cycle 2 (UnitDone=1), WRITE in cycle 3, Done in cycle 4.
REQ-029 The RUN counter SHALL be wide enough for TIMEOUT_CYC and SHALL saturate rather than wrap.

Reset
REQ-030 Reset=1 SHALL force IDLE on the next rising edge, clear the latched Op, counter and cause, and drive every output to 0.
REQ-031 Reset asserted mid-operation in any state SHALL abort without issuing RegHighW, RegLowW, Done or ExcpOut.
REQ-032 Reset SHALL take priority over Start and UnitDone in the same cycle.

Configuration
REQ-033 With macro MDC_TIMEOUT_EN defined, RUN SHALL go to EXCP with cause 10 when the counter reaches TIMEOUT_CYC-1 and UnitDone=0 in that cycle; UnitDone=1 in that same cycle SHALL win and go to WRITE.
REQ-034 Without MDC_TIMEOUT_EN, RUN SHALL wait indefinitely for UnitDone, ExcpCode 10 SHALL never occur, and the counter logic SHALL be omitted.

Verification
REQ-035 Mult: Start=1, Op=0; UnitDone=1 in the 1st RUN cycle -> MultStart in cycle 1, RegHighW=RegLowW=1 with DivMult=0 in cycle 3, Done in cycle 4, Busy high in cycles 1-3.
REQ-036 Div with a 32-cycle unit: Start=1, Op=1, DivZero=0; UnitDone after 32 RUN cycles -> DivStart pulse, DivMult=1 through WRITE, one HI/LO write, one Done pulse.
REQ-037 Divide by zero: Start=1, Op=1, DivZero=1 -> ExcpOut=1 with ExcpCode=01 next cycle; no DivStart, no RegHighW or RegLowW.
REQ-038 Busy ignore: Start held high through the whole operation -> exactly one operation; the next one starts only after IDLE is reached.
REQ-039 Reset in RUN at cycle 5 -> all outputs 0 next cycle, no Done or HI/LO write, and a fresh mult completes normally afterwards.
REQ-040 With MDC_TIMEOUT_EN and TIMEOUT_CYC=40, UnitDone never asserted -> ExcpOut=1 with ExcpCode=10 after 40 RUN cycles; without the macro, Busy stays high.

Source files
------------

// File: rtl/mult_div_ctrl.sv
// Sequencing controller for the HI/LO multiply/divide unit: start pulses, HI/LO write, completion and exceptions.
// Optional RUN-phase timeout is built only when MDC_TIMEOUT_EN is defined.
module mult_div_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 40
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Op,
    input  logic       DivZero,
    input  logic       UnitDone,
    output logic       MultStart,
    output logic       DivStart,
    output logic       DivMult,
    output logic       RegHighW,
    output logic       RegLowW,
    output logic       Busy,
    output logic       Done,
    output logic       ExcpOut,
    output logic [1:0] ExcpCode
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        RUN   = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        EXCP  = 3'd5
    } state_e;

    localparam logic [1:0] CAUSE_DIVZERO = 2'b01;

    state_e     state_q;
    logic       op_q;
    logic [1:0] cause_q;

`ifdef MDC_TIMEOUT_EN
    localparam int unsigned CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    logic [CNT_W-1:0] cnt_q;
`else
    // Timeout depth has no effect unless the watchdog is built.
    localparam int unsigned timeout_unused = TIMEOUT_CYC;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            cause_q <= 2'b00;
`ifdef MDC_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        op_q <= Op;
                        if (Op && DivZero) begin
                            cause_q <= CAUSE_DIVZERO;
                            state_q <= EXCP;
                        end else begin
                            state_q <= START;
                        end
                    end
                end
                START: begin
`ifdef MDC_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                    state_q <= RUN;
                end
                RUN: begin
                    if (UnitDone) begin
                        state_q <= WRITE;
                    end else begin
`ifdef MDC_TIMEOUT_EN
                        // Saturating count; UnitDone above already wins on the final cycle.
                        if (cnt_q != '1) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                        if (cnt_q == CNT_LAST) begin
                            cause_q <= CAUSE_TIMEOUT;
                            state_q <= EXCP;
                        end
`endif
                    end
                end
                WRITE:   state_q <= DONE;
                DONE:    state_q <= IDLE;
                EXCP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Moore decode straight from the state register and latched op.
    assign MultStart = (state_q == START) && !op_q;
    assign DivStart  = (state_q == START) && op_q;
    assign Busy      = (state_q == START) || (state_q == RUN) || (state_q == WRITE);
    assign DivMult   = Busy && op_q;
    assign RegHighW  = (state_q == WRITE);
    assign RegLowW   = (state_q == WRITE);
    assign Done      = (state_q == DONE);
    assign ExcpOut   = (state_q == EXCP);
    assign ExcpCode  = (state_q == EXCP) ? cause_q : 2'b00;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Randomized self-checking bench for mult_div_ctrl against a per-cycle transaction model.
module tb_mult_div_ctrl;

    localparam int unsigned TO = 40;

    logic       Clock = 1'b0;
    logic       Reset, Start, Op, DivZero, UnitDone;
    logic       MultStart, DivStart, DivMult, RegHighW, RegLowW, Busy, Done, ExcpOut;
    logic [1:0] ExcpCode;
    logic [9:0] obs;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst, st, op, dz, ud;
        logic [9:0] exp;
    } cyc_t;

    cyc_t       plan[$];
    logic [9:0] obs_q[$];

    mult_div_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Op(Op), .DivZero(DivZero),
        .UnitDone(UnitDone), .MultStart(MultStart), .DivStart(DivStart), .DivMult(DivMult),
        .RegHighW(RegHighW), .RegLowW(RegLowW), .Busy(Busy), .Done(Done),
        .ExcpOut(ExcpOut), .ExcpCode(ExcpCode)
    );

    always #5 Clock = ~Clock;

    assign obs = {MultStart, DivStart, DivMult, RegHighW, RegLowW, Busy, Done, ExcpOut, ExcpCode};

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [9:0] ov(logic ms, logic ds, logic dm, logic hw, logic lw,
                                      logic bz, logic dn, logic ex, logic [1:0] code);
        return {ms, ds, dm, hw, lw, bz, dn, ex, code};
    endfunction

    function automatic void push(logic rst, logic st, logic op, logic dz, logic ud, logic [9:0] exp);
        cyc_t c;
        c.rst = rst; c.st = st; c.op = op; c.dz = dz; c.ud = ud; c.exp = exp;
        plan.push_back(c);
    endfunction

    function automatic void plan_idle(int n);
        for (int i = 0; i < n; i++) push(1'b0, 1'b0, rb(), rb(), rb(), 10'd0);
    endfunction

    // One request: accept cycle, then the cycle-by-cycle outputs the protocol requires.
    // Inputs outside the accept cycle are noise (or Start held high) and must be ignored.
    function automatic void plan_txn(logic op, logic dz, int n_run, bit hold);
        push(1'b0, 1'b1, op, dz, rb(), 10'd0);
        if (op && dz) begin
            push(1'b0, hold ? 1'b1 : rb(), rb(), rb(), rb(),
                 ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01));
            return;
        end
        push(1'b0, hold ? 1'b1 : rb(), rb(), rb(), rb(),
             ov(~op, op, op, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00));
        for (int r = 1; r <= n_run; r++) begin
            push(1'b0, hold ? 1'b1 : rb(), rb(), rb(), (r == n_run),
                 ov(1'b0, 1'b0, op, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00));
`ifdef MDC_TIMEOUT_EN
            if (r == int'(TO) && r != n_run) begin
                push(1'b0, hold ? 1'b1 : rb(), rb(), rb(), rb(),
                     ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10));
                return;
            end
`endif
        end
        push(1'b0, hold ? 1'b1 : rb(), rb(), rb(), rb(),
             ov(1'b0, 1'b0, op, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00));
        push(1'b0, hold ? 1'b1 : rb(), rb(), rb(), rb(),
             ov(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00));
    endfunction

    // Observe the current cycle at the falling edge, then drive that cycle's inputs.
    task automatic play();
        obs_q.delete();
        foreach (plan[i]) begin
            @(negedge Clock);
            obs_q.push_back(obs);
            Reset    = plan[i].rst;
            Start    = plan[i].st;
            Op       = plan[i].op;
            DivZero  = plan[i].dz;
            UnitDone = plan[i].ud;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge Clock);
        for (int i = 0; i < 3; i++) push(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 10'd0);
        plan_idle(2);
        play();
        foreach (plan[i]) begin
            checks++;
            if (obs_q[i] !== plan[i].exp) begin
                failures++;
                $display("FAIL reset cyc%0d got=%b want=%b", i, obs_q[i], plan[i].exp);
            end
        end
        plan.delete();
    endtask

    task automatic test_mult();
        plan_txn(1'b0, 1'b0, 1, 1'b0);
        plan_txn(1'b0, 1'b1, 1, 1'b0);
        plan_idle(1);
        play();
        foreach (plan[i]) begin
            checks++;
            if (obs_q[i] !== plan[i].exp) begin
                failures++;
                $display("FAIL mult cyc%0d got=%b want=%b", i, obs_q[i], plan[i].exp);
            end
        end
        plan.delete();
    endtask

    task automatic test_div32();
        plan_txn(1'b1, 1'b0, 32, 1'b0);
        plan_idle(2);
        play();
        foreach (plan[i]) begin
            checks++;
            if (obs_q[i] !== plan[i].exp) begin
                failures++;
                $display("FAIL div32 cyc%0d got=%b want=%b", i, obs_q[i], plan[i].exp);
            end
        end
        plan.delete();
    endtask

    task automatic test_divzero();
        plan_txn(1'b1, 1'b1, 1, 1'b0);
        plan_idle(1);
        plan_txn(1'b1, 1'b1, 1, 1'b1);
        plan_idle(1);
        play();
        foreach (plan[i]) begin
            checks++;
            if (obs_q[i] !== plan[i].exp) begin
                failures++;
                $display("FAIL divzero cyc%0d got=%b want=%b", i, obs_q[i], plan[i].exp);
            end
        end
        plan.delete();
    endtask

    task automatic test_back_to_back();
        plan_txn(1'b0, 1'b0, 3, 1'b1);
        plan_txn(1'b1, 1'b0, 2, 1'b1);
        plan_txn(1'b1, 1'b1, 1, 1'b1);
        plan_txn(1'b0, 1'b0, 1, 1'b1);
        plan_idle(1);
        play();
        foreach (plan[i]) begin
            checks++;
            if (obs_q[i] !== plan[i].exp) begin
                failures++;
                $display("FAIL back_to_back cyc%0d got=%b want=%b", i, obs_q[i], plan[i].exp);
            end
        end
        plan.delete();
    endtask

    task automatic test_reset_mid();
        plan_txn(1'b0, 1'b0, 20, 1'b0);
        while (plan.size() > 7) void'(plan.pop_back());
        plan[6].rst = 1'b1;
        plan[6].st  = 1'b1;
        plan[6].ud  = 1'b1;
        push(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'd0);
        plan_txn(1'b0, 1'b0, 1, 1'b0);
        plan_idle(1);
        play();
        foreach (plan[i]) begin
            checks++;
            if (obs_q[i] !== plan[i].exp) begin
                failures++;
                $display("FAIL reset_mid cyc%0d got=%b want=%b", i, obs_q[i], plan[i].exp);
            end
        end
        plan.delete();
    endtask

    task automatic test_timeout();
        plan_txn(1'b1, 1'b0, 60, 1'b0);
        plan_idle(1);
        plan_txn(1'b0, 1'b0, int'(TO), 1'b0);
        plan_idle(1);
        play();
        foreach (plan[i]) begin
            checks++;
            if (obs_q[i] !== plan[i].exp) begin
                failures++;
                $display("FAIL timeout cyc%0d got=%b want=%b", i, obs_q[i], plan[i].exp);
            end
        end
        plan.delete();
    endtask

    task automatic test_random();
        for (int t = 0; t < 30; t++) begin
            plan_txn(rb(), rb(), int'($urandom_range(1, 45)), bit'(rb()));
            if (rb()) plan_idle(int'($urandom_range(1, 3)));
        end
        plan_idle(1);
        play();
        foreach (plan[i]) begin
            checks++;
            if (obs_q[i] !== plan[i].exp) begin
                failures++;
                $display("FAIL random cyc%0d got=%b want=%b", i, obs_q[i], plan[i].exp);
            end
        end
        plan.delete();
    endtask

    initial begin
        Reset    = 1'b1;
        Start    = 1'b0;
        Op       = 1'b0;
        DivZero  = 1'b0;
        UnitDone = 1'b0;
        test_reset();
        test_mult();
        test_div32();
        test_divzero();
        test_back_to_back();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
